// File: rtl/core_pkg.sv
// Shared core definitions: hazard controller state encoding, register-index
// width and the NOP instruction word loaded by the pipeline registers.
package core_pkg;

  localparam int REG_W = 5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment when enabled, never wrap past all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core. Resolves
// load-use, taken branch, multi-cycle EX and imem-wait hazards with
// zero-latency combinational controls. The FSM state is exported on
// state_dbg for observation.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_W       = core_pkg::REG_W,
  parameter int FLUSH_DEPTH = 1,
  parameter int MC_TIMEOUT  = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             ex_mem_bubble,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output hz_state_e        state_dbg
);

  localparam int MCNT_W = $clog2(MC_TIMEOUT) + 1;
  localparam logic [MCNT_W-1:0] MC_LIMIT   = MCNT_W'(MC_TIMEOUT);
  localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

  hz_state_e         state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              timeout_set;
  logic              flush_inc;
  logic              run_rules;
  logic              lu;

  assign state_dbg = state_q;

  // Load-use: the load in EX writes a register the ID instruction reads (x0 never hazards).
  always_comb begin
    lu = ex_mem_read && (ex_rd != '0) &&
         ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and control outputs; reset forces the safe flush/bubble pattern.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    mcnt_d        = mcnt_q;
    timeout_set   = 1'b0;
    flush_inc     = 1'b0;
    run_rules     = 1'b0;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          pc_write     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end else if (ex_mc_start && !ex_mc_done) begin
          ex_hold       = 1'b1;
          ex_mem_bubble = 1'b1;
          mcnt_d        = MCNT_W'(1);
          state_d       = MC_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      MC_WAIT: begin
        if (ex_mc_done) begin
          run_rules = 1'b1;
          state_d   = RUN;
        end else if (mcnt_q == MC_LIMIT) begin
          timeout_set = 1'b1;
          run_rules   = 1'b1;
          state_d     = RUN;
        end else begin
          ex_hold       = 1'b1;
          ex_mem_bubble = 1'b1;
          mcnt_d        = mcnt_q + MCNT_W'(1);
        end
      end
      FLUSH: begin
        pc_write    = imem_ready;
        if_id_flush = 1'b1;
        if (fcnt_q <= 4'd1) begin
          fcnt_d  = 4'd0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase

    // Lower-priority RUN rules, shared by RUN and the MC_WAIT release cycle.
    if (run_rules) begin
      if (lu) begin
        id_ex_bubble = 1'b1;
      end else if (!imem_ready) begin
        if_id_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_hold       = 1'b0;
      ex_mem_bubble = 1'b0;
    end
  end

  // State, internal counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fcnt_q     <= 4'd0;
      mcnt_q     <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
      if (timeout_set) begin
        mc_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random stimulus,
// each cycle compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int REG_W       = 5;
  localparam int FLUSH_DEPTH = 3;
  localparam int MC_TIMEOUT  = 64;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble}
  localparam logic [5:0] O_RESET  = 6'b001100;
  localparam logic [5:0] O_NORMAL = 6'b110000;
  localparam logic [5:0] O_BRANCH = 6'b101100;
  localparam logic [5:0] O_MCHOLD = 6'b000011;
  localparam logic [5:0] O_LU     = 6'b000100;
  localparam logic [5:0] O_IMEM   = 6'b001000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic ex_mc_start, ex_mc_done, imem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble;
  logic mc_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [1:0] state_dbg;

  hazard_ctrl #(
    .REG_W(REG_W), .FLUSH_DEPTH(FLUSH_DEPTH), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .imem_ready(imem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .mc_timeout(mc_timeout), .stall_count(stall_count), .flush_count(flush_count),
    .state_dbg(state_dbg)
  );

  wire [5:0] outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  int flush_left;   // flush cycles still owed after a taken branch
  bit mc_active;    // a multi-cycle op is holding EX
  int mc_held;      // cycles the current multi-cycle op has held EX so far
  bit to_m;
  int stall_m;
  int flush_m;

  task automatic model_reset();
    flush_left = 0;
    mc_active  = 0;
    mc_held    = 0;
    to_m       = 0;
    stall_m    = 0;
    flush_m    = 0;
  endtask

  function automatic bit load_use();
    if (!ex_mem_read || ex_rd == 0) return 0;
    return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_mc_start = 0; ex_mc_done = 0; imem_ready = 1;
  endtask

  // Called just after a rising edge with inputs applied; checks this cycle
  // against the model, advances the model, and returns just after the next edge.
  task automatic tick();
    logic [5:0] exp_o;
    logic [1:0] exp_st;
    bit normal;
    #3;
    exp_st = (flush_left > 0) ? 2'd2 : (mc_active ? 2'd1 : 2'd0);
    check("state", 32'(state_dbg), 32'(exp_st));
    check("stall_count", 32'(stall_count), stall_m);
    check("flush_count", 32'(flush_count), flush_m);
    check("mc_timeout", 32'(mc_timeout), 32'(to_m));
    exp_o  = 6'b0;
    normal = 0;
    if (flush_left > 0) begin
      exp_o = {imem_ready, 5'b01000};
      flush_left--;
    end else if (mc_active) begin
      if (ex_mc_done) begin
        mc_active = 0; normal = 1;
      end else if (mc_held == MC_TIMEOUT) begin
        mc_active = 0; to_m = 1; normal = 1;
      end else begin
        exp_o = O_MCHOLD; mc_held++;
      end
    end else if (ex_branch_taken) begin
      exp_o = O_BRANCH;
      flush_left = FLUSH_DEPTH - 1;
      if (flush_m < CNT_MAX) flush_m++;
    end else if (ex_mc_start && !ex_mc_done) begin
      exp_o = O_MCHOLD; mc_active = 1; mc_held = 1;
    end else begin
      normal = 1;
    end
    if (normal) begin
      if (load_use())       exp_o = O_LU;
      else if (!imem_ready) exp_o = O_IMEM;
      else                  exp_o = O_NORMAL;
    end
    check("ctrl", 32'(outs), 32'(exp_o));
    if (!exp_o[5] && stall_m < CNT_MAX) stall_m++;
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; holds reset across one edge.
  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    check("rst_ctrl", 32'(outs), 32'(O_RESET));
    check("rst_stall", 32'(stall_count), 0);
    check("rst_flush", 32'(flush_count), 0);
    check("rst_timeout", 32'(mc_timeout), 0);
    check("rst_state", 32'(state_dbg), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic rand_inputs();
    id_rs1 = REG_W'($urandom_range(0, 7));
    id_rs2 = REG_W'($urandom_range(0, 7));
    ex_rd  = REG_W'($urandom_range(0, 7));
    id_uses_rs1 = 1'($urandom_range(0, 1));
    id_uses_rs2 = 1'($urandom_range(0, 1));
    ex_mem_read = ($urandom_range(0, 2) == 0);
    ex_branch_taken = ($urandom_range(0, 5) == 0);
    ex_mc_start = ($urandom_range(0, 9) == 0);
    ex_mc_done  = ($urandom_range(0, 11) == 0);
    imem_ready  = ($urandom_range(0, 4) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Load-use on rs1, then the load leaves EX.
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    tick();
    ex_mem_read = 0;
    tick();
    check("lu_stall_count", 32'(stall_count), 1);

    // x0 destination and an unused matching operand never stall.
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    tick();
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 0;
    tick();
    check("nostall_count", 32'(stall_count), 1);

    // Taken branch with three flush cycles.
    do_reset();
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    tick();
    ex_branch_taken = 1;   // ignored while flushing
    tick();
    ex_branch_taken = 0;
    check("br_flush_count", 32'(flush_count), 1);
    check("br_state_back", 32'(state_dbg), 0);
    tick();

    // Branch beats load-use and imem wait.
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1; imem_ready = 0;
    #3;
    check("prio_branch", 32'(outs), 32'(O_BRANCH));
    #(-0);
    @(posedge clk); #1;
    // Keep the model in step: that cycle was a branch entering flush.
    flush_left = FLUSH_DEPTH - 1;
    if (flush_m < CNT_MAX) flush_m++;
    idle_inputs();
    repeat (3) tick();

    // Multi-cycle op completing after 10 cycles.
    do_reset();
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    repeat (9) tick();
    ex_mc_done = 1;
    tick();
    ex_mc_done = 0;
    check("mc_done_timeout", 32'(mc_timeout), 0);
    check("mc_done_stalls", 32'(stall_count), 10);

    // Multi-cycle op that never completes: forced release and sticky flag.
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    repeat (MC_TIMEOUT) tick();
    check("mc_to_flag", 32'(mc_timeout), 1);
    check("mc_to_stalls", 32'(stall_count), 74);
    repeat (4) tick();
    check("mc_to_sticky", 32'(mc_timeout), 1);

    // Asynchronous reset in the middle of MC_WAIT.
    ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    repeat (3) tick();
    #2;
    rst_n = 0;
    #1;
    check("async_ctrl", 32'(outs), 32'(O_RESET));
    check("async_state", 32'(state_dbg), 0);
    check("async_stall", 32'(stall_count), 0);
    check("async_timeout", 32'(mc_timeout), 0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    // Random traffic, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      rand_inputs();
      tick();
    end
    idle_inputs();
    repeat (MC_TIMEOUT + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
